// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl: SPI mode-0 memory controller for 1..4 byte reads (0x03)
// and writes (0x02). The whole block runs on clk; SCLK is a registered
// output toggled by a half-period counter, never a gated clock.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   req_valid/ready   request handshake, accepted when both are high
//   req_write         1 = write, 0 = read
//   req_addr          [31:24] chip-select index, low bytes device address
//   req_nbytes        byte count, legal 1..4
//   req_wdata         write data, little-endian (byte 0 sent first)
//   resp_valid        one-cycle completion pulse
//   resp_rdata        read data packed byte 0 in [7:0]
//   resp_err          illegal request flag, valid with resp_valid
//   sclk, mosi, miso  SPI bus (mode 0, SCLK idles low)
//   cs_n              active-low chip selects, at most one low

module spi_mem_ctrl #(
    parameter int NUM_CS       = 2,
    parameter int ADDR_BYTES   = 3,
    parameter int CLK_DIV      = 1,
    parameter int CS_SETUP_CYC = 1,
    parameter int CS_HOLD_CYC  = 1,
    parameter int CS_IDLE_CYC  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [2:0]        req_nbytes,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_CS-1:0] cs_n
);

    // Worst case frame: opcode + 4 address bytes + 4 data bytes.
    localparam int TXW = 72;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_RESP,
        S_GAP
    } state_t;

    state_t          state;
    logic            is_write;
    logic [2:0]      nbytes;
    logic [7:0]      nbits;
    logic [7:0]      bit_cnt;
    logic [15:0]     half_cnt;
    logic [15:0]     cyc_cnt;
    logic [TXW-1:0]  tx;
    logic [31:0]     rx;

    logic [7:0]        cs_idx;
    logic              bad_req;
    logic [7:0]        opcode;
    logic [31:0]       wfield;
    logic [TXW-1:0]    tx_init;
    logic [7:0]        nbits_init;
    logic [NUM_CS-1:0] cs_sel;
    logic [31:0]       rdata_pack;

    always_comb begin
        cs_idx  = req_addr[31:24];
        bad_req = ({24'h0, cs_idx} >= 32'(NUM_CS))
                  || (req_nbytes == 3'd0)
                  || (req_nbytes > 3'd4);
        opcode  = req_write ? 8'h02 : 8'h03;
        // Write bytes go out byte 0 first, so swap into MSB-first order.
        wfield  = req_write ? {req_wdata[7:0], req_wdata[15:8],
                               req_wdata[23:16], req_wdata[31:24]}
                            : 32'h0;
        if (ADDR_BYTES == 4)
            tx_init = {opcode, req_addr, wfield};
        else
            tx_init = {opcode, req_addr[23:0], wfield, 8'h00};
        nbits_init = 8'(8 * (1 + ADDR_BYTES))
                     + {2'b00, req_nbytes, 3'b000};
        cs_sel = ~(NUM_CS'(1) << cs_idx);
    end

    // rx keeps the last 32 sampled bits; the data bytes are the low
    // 8*nbytes of them with the first received byte most significant.
    always_comb begin
        rdata_pack = 32'h0;
        case (nbytes)
            3'd1: rdata_pack = {24'h0, rx[7:0]};
            3'd2: rdata_pack = {16'h0, rx[7:0], rx[15:8]};
            3'd3: rdata_pack = {8'h0, rx[7:0], rx[15:8], rx[23:16]};
            3'd4: rdata_pack = {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
            default: rdata_pack = 32'h0;
        endcase
        if (is_write)
            rdata_pack = 32'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            sclk       <= 1'b0;
            mosi       <= 1'b0;
            cs_n       <= '1;
            is_write   <= 1'b0;
            nbytes     <= 3'd0;
            nbits      <= 8'd0;
            bit_cnt    <= 8'd0;
            half_cnt   <= 16'd0;
            cyc_cnt    <= 16'd0;
            tx         <= '0;
            rx         <= 32'h0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        is_write  <= req_write;
                        nbytes    <= req_nbytes;
                        nbits     <= nbits_init;
                        tx        <= tx_init;
                        rx        <= 32'h0;
                        cyc_cnt   <= 16'd0;
                        if (bad_req) begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            state <= S_SETUP;
                            cs_n  <= cs_sel;
                            mosi  <= tx_init[TXW-1];
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                S_SETUP: begin
                    if (cyc_cnt == 16'(CS_SETUP_CYC - 1)) begin
                        state    <= S_SHIFT;
                        half_cnt <= 16'd0;
                        bit_cnt  <= 8'd0;
                    end else begin
                        cyc_cnt <= cyc_cnt + 16'd1;
                    end
                end
                S_SHIFT: begin
                    if (half_cnt == 16'(CLK_DIV - 1)) begin
                        half_cnt <= 16'd0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                            rx   <= {rx[30:0], miso};
                        end else begin
                            sclk    <= 1'b0;
                            tx      <= {tx[TXW-2:0], 1'b0};
                            mosi    <= tx[TXW-2];
                            bit_cnt <= bit_cnt + 8'd1;
                            if (bit_cnt + 8'd1 == nbits) begin
                                state   <= S_HOLD;
                                mosi    <= 1'b0;
                                cyc_cnt <= 16'd0;
                            end
                        end
                    end else begin
                        half_cnt <= half_cnt + 16'd1;
                    end
                end
                S_HOLD: begin
                    if (cyc_cnt == 16'(CS_HOLD_CYC - 1)) begin
                        state      <= S_RESP;
                        cs_n       <= '1;
                        resp_valid <= 1'b1;
                        resp_rdata <= rdata_pack;
                    end else begin
                        cyc_cnt <= cyc_cnt + 16'd1;
                    end
                end
                S_RESP: begin
                    cyc_cnt <= 16'd0;
                    if (CS_IDLE_CYC == 0) begin
                        state     <= S_IDLE;
                        req_ready <= 1'b1;
                    end else begin
                        state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (cyc_cnt == 16'(CS_IDLE_CYC - 1)) begin
                        state     <= S_IDLE;
                        req_ready <= 1'b1;
                    end else begin
                        cyc_cnt <= cyc_cnt + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// tb_spi_mem_ctrl: directed bench for spi_mem_ctrl with a default
// instance and a CLK_DIV=3 / ADDR_BYTES=4 instance sharing one SPI model.

module tb_spi_mem_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [2:0]  req_nbytes = 3'd1;
    logic [31:0] req_wdata = 32'h0;
    logic        miso;

    logic        rdy0, rdy1, rv0, rv1, err0, err1;
    logic        sclk0, sclk1, mosi0, mosi1;
    logic [31:0] rd0, rd1;
    logic [1:0]  cs0, cs1;

    spi_mem_ctrl u0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & !sel), .req_ready(rdy0),
        .req_write(req_write), .req_addr(req_addr),
        .req_nbytes(req_nbytes), .req_wdata(req_wdata),
        .resp_valid(rv0), .resp_rdata(rd0), .resp_err(err0),
        .sclk(sclk0), .mosi(mosi0), .miso(miso), .cs_n(cs0)
    );

    spi_mem_ctrl #(.CLK_DIV(3), .ADDR_BYTES(4)) u1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & sel), .req_ready(rdy1),
        .req_write(req_write), .req_addr(req_addr),
        .req_nbytes(req_nbytes), .req_wdata(req_wdata),
        .resp_valid(rv1), .resp_rdata(rd1), .resp_err(err1),
        .sclk(sclk1), .mosi(mosi1), .miso(miso), .cs_n(cs1)
    );

    logic        rdy, rv, err, sclk_m, mosi_m;
    logic [31:0] rd;
    logic [1:0]  cs_m;
    assign rdy    = sel ? rdy1 : rdy0;
    assign rv     = sel ? rv1 : rv0;
    assign err    = sel ? err1 : err0;
    assign rd     = sel ? rd1 : rd0;
    assign sclk_m = sel ? sclk1 : sclk0;
    assign mosi_m = sel ? mosi1 : mosi0;
    assign cs_m   = sel ? cs1 : cs0;

    // SPI device model: bit n of dev_tx (from the top) is driven before
    // the n-th rising SCLK of the current transaction.
    int          rise_cnt = 0;
    int          base = 0;
    logic [71:0] dev_tx = '0;
    logic [71:0] mosi_cap = '0;

    always @(posedge sclk_m) begin
        rise_cnt <= rise_cnt + 1;
        mosi_cap <= {mosi_cap[70:0], mosi_m};
    end

    always_comb begin
        int rel;
        rel  = rise_cnt - base;
        miso = 1'b0;
        if (rel >= 0 && rel < 72)
            miso = dev_tx[7'(71 - rel)];
    end

    int   run = 0, hi_len = 0, lo_len = 0, cs_multi = 0;
    logic prev = 1'b0;
    always @(negedge clk) begin
        if (sclk_m !== prev) begin
            if (prev) hi_len <= run;
            else      lo_len <= run;
            run <= 1;
        end else begin
            run <= run + 1;
        end
        prev <= sclk_m;
        if ($countones(~cs0) > 1 || $countones(~cs1) > 1)
            cs_multi <= cs_multi + 1;
    end

    int ncmp = 0;
    int nfail = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int          lat, wait_cyc;
    logic [31:0] got_rd;
    logic        got_err;
    logic [1:0]  got_cs;
    bit          cs_low_any, wait_hi_ok;

    // Present a request and return just after its accept edge.
    task automatic start(input logic w, input logic [31:0] a,
                         input logic [2:0] nb, input logic [31:0] wd,
                         input logic [31:0] dd, input int hdr);
        int k;
        @(negedge clk);
        req_write  = w;
        req_addr   = a;
        req_nbytes = nb;
        req_wdata  = wd;
        req_valid  = 1'b1;
        base       = rise_cnt;
        dev_tx     = {dd, 40'h0} >> hdr;
        wait_cyc   = 0;
        wait_hi_ok = 1'b1;
        k = 0;
        while (!rdy && k < 400) begin
            if (cs_m !== 2'b11) wait_hi_ok = 1'b0;
            wait_cyc++;
            @(negedge clk);
            k++;
        end
        if (!rdy) check("accept_timeout", {63'h0, rdy}, 64'd1);
        @(posedge clk);
    endtask

    // Wait for the response; lat = posedge index at which it is seen.
    task automatic finish(input bit hold);
        int n;
        n = 0;
        cs_low_any = 1'b0;
        got_cs = 2'b11;
        lat = 0;
        got_rd = 32'h0;
        got_err = 1'b0;
        while (n < 2000) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                got_cs = cs_m;
                if (!hold) begin
                    req_valid  = 1'b0;
                    req_addr   = 32'hFFFF_FFFF;
                    req_wdata  = 32'h0BAD_F00D;
                    req_nbytes = 3'd7;
                    req_write  = ~req_write;
                end
            end
            if (cs_m !== 2'b11) cs_low_any = 1'b1;
            if (rv) begin
                lat = n;
                got_rd = rd;
                got_err = err;
                break;
            end
        end
        check("resp_seen", {63'h0, rv}, 64'd1);
    endtask

    logic [31:0] ill_addr [3];
    logic [2:0]  ill_nb [3];

    initial begin
        int k, rvcnt;
        ill_addr[0] = 32'h0500_0000; ill_nb[0] = 3'd1;
        ill_addr[1] = 32'h0000_0000; ill_nb[1] = 3'd0;
        ill_addr[2] = 32'h0000_0000; ill_nb[2] = 3'd5;

        repeat (3) @(negedge clk);
        check("rst_ready", {63'h0, rdy0}, 64'd0);
        check("rst_valid", {63'h0, rv0}, 64'd0);
        check("rst_rdata", {32'h0, rd0}, 64'h0);
        check("rst_err", {63'h0, err0}, 64'd0);
        check("rst_sclk", {63'h0, sclk0}, 64'd0);
        check("rst_mosi", {63'h0, mosi0}, 64'd0);
        check("rst_cs0", {62'h0, cs0}, 64'h3);
        check("rst_cs1", {62'h0, cs1}, 64'h3);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {63'h0, rdy0}, 64'd1);

        // 4-byte read on CS0
        start(1'b0, 32'h0000_1234, 3'd4, 32'h0, 32'hDEAD_BEEF, 32);
        finish(1'b0);
        check("rd4_lat", 64'(lat), 64'd131);
        check("rd4_rdata", {32'h0, got_rd}, 64'hEFBE_ADDE);
        check("rd4_err", {63'h0, got_err}, 64'd0);
        check("rd4_cs", {62'h0, got_cs}, 64'h2);
        check("rd4_rises", 64'(rise_cnt - base), 64'd64);
        check("rd4_mosi", mosi_cap[63:0], 64'h0300_1234_0000_0000);

        // 2-byte write on CS1
        start(1'b1, 32'h0100_0010, 3'd2, 32'h0000_A55A, 32'h0, 32);
        finish(1'b0);
        check("wr2_lat", 64'(lat), 64'd99);
        check("wr2_err", {63'h0, got_err}, 64'd0);
        check("wr2_cs", {62'h0, got_cs}, 64'h1);
        check("wr2_rises", 64'(rise_cnt - base), 64'd48);
        check("wr2_mosi", {16'h0, mosi_cap[47:0]}, 64'h0200_0010_5AA5);

        // divided clock, 4 address bytes
        @(negedge clk);
        sel = 1'b1;
        start(1'b0, 32'h0100_5678, 3'd1, 32'h0, 32'h7E00_0000, 40);
        finish(1'b0);
        check("div3_lat", 64'(lat), 64'd291);
        check("div3_rdata", {32'h0, got_rd}, 64'h7E);
        check("div3_cs", {62'h0, got_cs}, 64'h1);
        check("div3_rises", 64'(rise_cnt - base), 64'd48);
        check("div3_mosi", {16'h0, mosi_cap[47:0]}, 64'h0301_0056_7800);
        check("div3_hi", 64'(hi_len), 64'd3);
        check("div3_lo", 64'(lo_len), 64'd3);
        @(negedge clk);
        sel = 1'b0;

        // illegal requests
        for (int i = 0; i < 3; i++) begin
            start(1'b0, ill_addr[i], ill_nb[i], 32'h0, 32'h0, 32);
            finish(1'b0);
            check($sformatf("ill%0d_lat", i), 64'(lat), 64'd1);
            check($sformatf("ill%0d_err", i), {63'h0, got_err}, 64'd1);
            check($sformatf("ill%0d_rdata", i), {32'h0, got_rd}, 64'h0);
            check($sformatf("ill%0d_rises", i), 64'(rise_cnt - base), 64'd0);
            check($sformatf("ill%0d_cs", i), {63'h0, cs_low_any}, 64'd0);
        end

        // reset during the 20th bit
        start(1'b0, 32'h0000_0100, 3'd4, 32'h0, 32'h1234_5678, 32);
        k = 0;
        while ((rise_cnt - base) < 20 && k < 500) begin
            @(negedge clk);
            if (k == 0) req_valid = 1'b0;
            k++;
        end
        check("abort_bit", 64'(rise_cnt - base), 64'd20);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_cs", {62'h0, cs_m}, 64'h3);
        check("abort_sclk", {63'h0, sclk_m}, 64'd0);
        check("abort_mosi", {63'h0, mosi_m}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready", {63'h0, rdy}, 64'd1);
        rvcnt = 0;
        repeat (200) begin
            @(negedge clk);
            if (rv) rvcnt++;
        end
        check("abort_noresp", 64'(rvcnt), 64'd0);
        start(1'b0, 32'h0000_0200, 3'd2, 32'h0, 32'h1357_0000, 32);
        finish(1'b0);
        check("post_lat", 64'(lat), 64'd99);
        check("post_rdata", {32'h0, got_rd}, 64'h5713);
        check("post_err", {63'h0, got_err}, 64'd0);

        // back-to-back with req_valid held high
        start(1'b0, 32'h0100_0020, 3'd1, 32'h0, 32'h1100_0000, 32);
        finish(1'b1);
        check("b2b1_lat", 64'(lat), 64'd83);
        check("b2b1_rdata", {32'h0, got_rd}, 64'h11);
        check("b2b1_cs", {62'h0, got_cs}, 64'h1);
        start(1'b0, 32'h0000_0040, 3'd3, 32'h0, 32'h2233_4400, 32);
        check("b2b_gap", 64'(wait_cyc), 64'd2);
        check("b2b_gap_cs", {63'h0, wait_hi_ok}, 64'd1);
        finish(1'b0);
        check("b2b2_lat", 64'(lat), 64'd115);
        check("b2b2_rdata", {32'h0, got_rd}, 64'h44_3322);
        check("b2b2_cs", {62'h0, got_cs}, 64'h2);

        check("cs_onehot", 64'(cs_multi), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule
